// File: rtl/instr_fetch_unit_pkg.sv
// Purpose : shared types and constants for the instruction fetch unit.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Holds the fetch FSM state encoding, the error-cause codes reported to the
// control FSM, the datapath width and a small alignment helper.
package instr_fetch_unit_pkg;

    localparam int XLEN = 32;

    // Fetch FSM states. DRAIN swallows the single outstanding response of an
    // aborted (flushed or timed-out) transaction so it never reaches the IR.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } fetch_state_e;

    typedef logic [1:0] err_cause_t;

    localparam err_cause_t ERR_NONE     = 2'b00;
    localparam err_cause_t ERR_MISALIGN = 2'b01;
    localparam err_cause_t ERR_BUS      = 2'b10;
    localparam err_cause_t ERR_TIMEOUT  = 2'b11;

    // Instruction fetches must be word aligned; only the two low address
    // bits matter.
    function automatic logic is_word_aligned(input logic [1:0] addr_lo);
        return (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Purpose : instruction-memory request/grant/response bus between the fetch
//           unit (master) and the instruction memory (slave).
// Latency : n/a (wiring only).
// Backpressure: request held by the master until mem_gnt_i; responses are
//           never stalled (at most one outstanding transaction).
//
// Signals:
//   mem_req_o    master->slave  request, held until granted
//   mem_addr_o   master->slave  word-aligned address, stable while requesting
//   mem_gnt_i    slave->master  request accepted this cycle
//   mem_rvalid_i slave->master  read data valid (earliest one cycle after grant)
//   mem_rdata_i  slave->master  read data
//   mem_err_i    slave->master  bus error, qualified by mem_rvalid_i
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            mem_err_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i,
        input  mem_err_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i,
        output mem_err_i
    );

endinterface

// File: rtl/instr_fetch_unit_timeout.sv
// Purpose : bus-timeout counter for one fetch transaction.
// Latency : expired_o is combinational from the count and en_i; it fires in
//           the TIMEOUT_CYCLES-th enabled cycle after a clear.
// Backpressure: none; the owner clears it on entry to the request phase.
//
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   clr_i          restart the count (priority over en_i)
//   en_i           count this cycle (fetch in REQ or WAIT)
//   expired_o      this enabled cycle is the last allowed one
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    // A zero limit disables the timeout; keep a 1-bit counter so the
    // declarations stay legal.
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TMO_ON = (TIMEOUT_CYCLES > 0);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The count holds the number of cycles already spent, so the cycle in
    // which it equals LIMIT-1 is the last one; the FSM leaves REQ/WAIT on
    // that edge and the counter never wraps.
    assign expired_o = TMO_ON && en_i && (cnt_q == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose : fetch one 32-bit instruction per control-FSM request and write it
//           to the instruction register; report done or error.
// Latency : 3 cycles request-to-ir_en_o minimum (req, grant, rvalid, done);
//           misaligned PCs error out 1 cycle after the request.
// Backpressure: mem_req_o is held until mem_gnt_i; fetch_req_i is only
//           sampled in IDLE, so requests while busy_o is high are dropped.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   fetch_req_i, pc_i    fetch request and address (sampled in IDLE)
//   flush_i              abort the current fetch, IR not written
//   mem                  instruction-memory bus (master side)
//   ir_en_o, ir_d_o      one-cycle IR write enable and instruction word
//   fetch_done_o         one-cycle pulse: instruction written
//   fetch_err_o          one-cycle pulse: misaligned, bus error or timeout
//   err_cause_o          last error cause, cleared when a fetch is accepted
//   busy_o               high in every state except IDLE
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned     TIMEOUT_CYCLES = 255,
    parameter logic [XLEN-1:0] RESET_ADDR     = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 fetch_req_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic                 flush_i,
    instr_fetch_unit_if.master   mem,
    output logic                 ir_en_o,
    output logic [XLEN-1:0]      ir_d_o,
    output logic                 fetch_done_o,
    output logic                 fetch_err_o,
    output logic [1:0]           err_cause_o,
    output logic                 busy_o
);

    fetch_state_e    state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] ir_d_q, ir_d_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    err_cause_t      cause_q, cause_d;
    logic            busy_q, busy_d;
    // Set when an error leaves a granted transaction without its response;
    // ERR then hands over to DRAIN instead of IDLE.
    logic            drain_q, drain_d;

    logic            tmo_clr;
    logic            tmo_en;
    logic            tmo_expired;

    assign tmo_en = (state_q == REQ) || (state_q == WAIT);

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    // State and all outputs are registered together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_ADDR;
            ir_d_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cause_q    <= ERR_NONE;
            busy_q     <= 1'b0;
            drain_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ir_d_q     <= ir_d_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cause_q    <= cause_d;
            busy_q     <= busy_d;
            drain_q    <= drain_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ir_d_d     = ir_d_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cause_d    = cause_q;
        drain_d    = drain_q;
        tmo_clr    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fetch_req_i) begin
                    cause_d = ERR_NONE;
                    if (!is_word_aligned(pc_i[1:0])) begin
                        // No bus traffic for a misaligned PC; the request
                        // address keeps its previous (aligned) value.
                        state_d = ERR;
                        err_d   = 1'b1;
                        cause_d = ERR_MISALIGN;
                        drain_d = 1'b0;
                    end else begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_i;
                        tmo_clr    = 1'b1;
                    end
                end
            end

            REQ: begin
                // Any rvalid seen here cannot belong to this fetch.
                if (flush_i) begin
                    mem_req_d = 1'b0;
                    state_d   = mem.mem_gnt_i ? DRAIN : IDLE;
                end else if (mem.mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    if (tmo_expired) begin
                        // Granted on the last allowed cycle: report the
                        // timeout but still swallow the response later.
                        state_d = ERR;
                        err_d   = 1'b1;
                        cause_d = ERR_TIMEOUT;
                        drain_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (tmo_expired) begin
                    mem_req_d = 1'b0;
                    state_d   = ERR;
                    err_d     = 1'b1;
                    cause_d   = ERR_TIMEOUT;
                    drain_d   = 1'b0;
                end
            end

            WAIT: begin
                if (flush_i) begin
                    // A response in the flush cycle is already consumed.
                    state_d = mem.mem_rvalid_i ? IDLE : DRAIN;
                end else if (mem.mem_rvalid_i) begin
                    if (mem.mem_err_i) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        cause_d = ERR_BUS;
                        drain_d = 1'b0;
                    end else begin
                        state_d = DONE;
                        ir_d_d  = mem.mem_rdata_i;
                        done_d  = 1'b1;
                    end
                end else if (tmo_expired) begin
                    // Response checked first: on the limit cycle it wins.
                    state_d = ERR;
                    err_d   = 1'b1;
                    cause_d = ERR_TIMEOUT;
                    drain_d = 1'b1;
                end
            end

            DRAIN: begin
                if (mem.mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            ERR: begin
                // A late response may already land during the ERR cycle;
                // in that case there is nothing left to drain.
                drain_d = 1'b0;
                if (drain_q && !mem.mem_rvalid_i) begin
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                drain_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign mem.mem_req_o  = mem_req_q;
    assign mem.mem_addr_o = mem_addr_q;
    assign ir_en_o        = done_q;
    assign fetch_done_o   = done_q;
    assign ir_d_o         = ir_d_q;
    assign fetch_err_o    = err_q;
    assign err_cause_o    = cause_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose : self-checking bench for instr_fetch_unit.
// Latency : n/a.
// Backpressure: memory side driven directly by each scenario task.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int unsigned TMO      = 8;
    localparam logic [31:0] RST_ADDR = 32'h0000_1000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fetch_req_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        ir_en_o;
    logic [31:0] ir_d_o;
    logic        fetch_done_o;
    logic        fetch_err_o;
    logic [1:0]  err_cause_o;
    logic        busy_o;

    instr_fetch_unit_if mem_if ();

    instr_fetch_unit #(
        .TIMEOUT_CYCLES (TMO),
        .RESET_ADDR     (RST_ADDR)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fetch_req_i  (fetch_req_i),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .mem          (mem_if),
        .ir_en_o      (ir_en_o),
        .ir_d_o       (ir_d_o),
        .fetch_done_o (fetch_done_o),
        .fetch_err_o  (fetch_err_o),
        .err_cause_o  (err_cause_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        logic [1:0]  cause;
        int          cycle;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_ir;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Every done/err pulse must match the next expected completion.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni === 1'b1 && (ir_en_o || fetch_done_o || fetch_err_o)) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d en=%b done=%b err=%b cause=%b, required no pulse",
                         cyc, ir_en_o, fetch_done_o, fetch_err_o, err_cause_o);
            end else begin
                e = sb_q.pop_front();
                if ({ir_en_o, fetch_done_o, fetch_err_o, err_cause_o} !== {!e.is_err, !e.is_err, e.is_err, e.cause}
                    || cyc != e.cycle || (!e.is_err && ir_d_o !== e.data)) begin
                    errors++;
                    $display("FAIL scoreboard got en/done/err/cause=%b%b%b%b ir_d=%h cyc=%0d, required %b%b%b%b ir_d=%h cyc=%0d",
                             ir_en_o, fetch_done_o, fetch_err_o, err_cause_o, ir_d_o, cyc,
                             !e.is_err, !e.is_err, e.is_err, e.cause, e.data, e.cycle);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; fetch_req_i = 1'b0; pc_i = '0; flush_i = 1'b0;
        mem_if.mem_gnt_i = 1'b0; mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i = '0; mem_if.mem_err_i = 1'b0;
        tick(); tick();
        checks++;
        if ({mem_if.mem_req_o, ir_en_o, fetch_done_o, fetch_err_o, busy_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got req/en/done/err/busy=%b%b%b%b%b, required 00000",
                     mem_if.mem_req_o, ir_en_o, fetch_done_o, fetch_err_o, busy_o);
        end
        checks++;
        if (mem_if.mem_addr_o !== RST_ADDR) begin
            errors++;
            $display("FAIL reset_addr got %h, required %h", mem_if.mem_addr_o, RST_ADDR);
        end
        checks++;
        if (ir_d_o !== 32'h0 || err_cause_o !== ERR_NONE) begin
            errors++;
            $display("FAIL reset_ir_cause got ir_d=%h cause=%b, required 0 00", ir_d_o, err_cause_o);
        end
        #2 rst_ni = 1'b1;
        tick();
        last_ir = 32'h0;
    endtask

    task automatic test_normal();
        int c = cyc;
        fetch_req_i = 1'b1; pc_i = 32'h0000_0010;
        sb_q.push_back('{is_err: 1'b0, data: 32'h0051_8193, cause: ERR_NONE, cycle: c + 3});
        tick(); fetch_req_i = 1'b0;
        checks++;
        if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h10 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL normal_req got req=%b addr=%h busy=%b, required 1 00000010 1",
                     mem_if.mem_req_o, mem_if.mem_addr_o, busy_o);
        end
        mem_if.mem_gnt_i = 1'b1;
        tick(); mem_if.mem_gnt_i = 1'b0;
        checks++;
        if (mem_if.mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL normal_req_drop got req=%b, required 0", mem_if.mem_req_o);
        end
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'h0051_8193;
        tick(); mem_if.mem_rvalid_i = 1'b0; mem_if.mem_rdata_i = '0;
        checks++;
        if (ir_en_o !== 1'b1 || fetch_done_o !== 1'b1 || ir_d_o !== 32'h0051_8193) begin
            errors++;
            $display("FAIL normal_done got en=%b done=%b ir_d=%h, required 1 1 00518193",
                     ir_en_o, fetch_done_o, ir_d_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || ir_en_o !== 1'b0) begin
            errors++;
            $display("FAIL normal_idle got busy=%b en=%b, required 0 0", busy_o, ir_en_o);
        end
        last_ir = 32'h0051_8193;
    endtask

    task automatic test_delayed_grant();
        int c = cyc;
        fetch_req_i = 1'b1; pc_i = 32'h0000_0100;
        sb_q.push_back('{is_err: 1'b0, data: 32'h1234_5678, cause: ERR_NONE, cycle: c + 7});
        tick(); fetch_req_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h100) begin
                errors++;
                $display("FAIL delayed_hold_%0d got req=%b addr=%h, required 1 00000100",
                         k, mem_if.mem_req_o, mem_if.mem_addr_o);
            end
            // A stray response while still requesting must be ignored.
            mem_if.mem_rvalid_i = (k == 1);
            mem_if.mem_rdata_i  = (k == 1) ? 32'hBAD0_BAD0 : 32'h0;
            tick();
        end
        mem_if.mem_rvalid_i = 1'b0; mem_if.mem_rdata_i = '0;
        mem_if.mem_gnt_i = 1'b1;
        tick(); mem_if.mem_gnt_i = 1'b0;
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'h1234_5678;
        tick(); mem_if.mem_rvalid_i = 1'b0; mem_if.mem_rdata_i = '0;
        checks++;
        if (ir_en_o !== 1'b1 || ir_d_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL delayed_done got en=%b ir_d=%h, required 1 12345678", ir_en_o, ir_d_o);
        end
        tick();
        last_ir = 32'h1234_5678;
    endtask

    task automatic test_misaligned();
        int c = cyc;
        fetch_req_i = 1'b1; pc_i = 32'h0000_0006;
        sb_q.push_back('{is_err: 1'b1, data: 32'h0, cause: ERR_MISALIGN, cycle: c + 1});
        tick(); fetch_req_i = 1'b0;
        checks++;
        if (fetch_err_o !== 1'b1 || err_cause_o !== ERR_MISALIGN || mem_if.mem_req_o !== 1'b0 || ir_en_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_err got err=%b cause=%b req=%b en=%b, required 1 01 0 0",
                     fetch_err_o, err_cause_o, mem_if.mem_req_o, ir_en_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || err_cause_o !== ERR_MISALIGN || mem_if.mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_hold got busy=%b cause=%b req=%b, required 0 01 0",
                     busy_o, err_cause_o, mem_if.mem_req_o);
        end
    endtask

    task automatic test_bus_error();
        int c = cyc;
        fetch_req_i = 1'b1; pc_i = 32'h0000_0020;
        sb_q.push_back('{is_err: 1'b1, data: 32'h0, cause: ERR_BUS, cycle: c + 3});
        tick(); fetch_req_i = 1'b0; mem_if.mem_gnt_i = 1'b1;
        tick(); mem_if.mem_gnt_i = 1'b0;
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_err_i = 1'b1; mem_if.mem_rdata_i = 32'hFFFF_FFFF;
        tick(); mem_if.mem_rvalid_i = 1'b0; mem_if.mem_err_i = 1'b0; mem_if.mem_rdata_i = '0;
        checks++;
        if (fetch_err_o !== 1'b1 || err_cause_o !== ERR_BUS || ir_en_o !== 1'b0 || ir_d_o !== last_ir) begin
            errors++;
            $display("FAIL bus_err got err=%b cause=%b en=%b ir_d=%h, required 1 10 0 %h",
                     fetch_err_o, err_cause_o, ir_en_o, ir_d_o, last_ir);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || err_cause_o !== ERR_BUS || ir_d_o !== last_ir) begin
            errors++;
            $display("FAIL bus_err_after got busy=%b cause=%b ir_d=%h, required 0 10 %h",
                     busy_o, err_cause_o, ir_d_o, last_ir);
        end
    endtask

    // fetch_req_i stays high across the first fetch: it is ignored until
    // IDLE, then accepted again with the new PC.
    task automatic test_back_to_back();
        int c = cyc;
        fetch_req_i = 1'b1; pc_i = 32'h0000_0040;
        sb_q.push_back('{is_err: 1'b0, data: 32'hA0A0_0001, cause: ERR_NONE, cycle: c + 3});
        sb_q.push_back('{is_err: 1'b0, data: 32'hB0B0_0002, cause: ERR_NONE, cycle: c + 7});
        tick(); pc_i = 32'h0000_0044;
        checks++;
        if (err_cause_o !== ERR_NONE || mem_if.mem_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL b2b_cause_clear got cause=%b addr=%h, required 00 00000040",
                     err_cause_o, mem_if.mem_addr_o);
        end
        mem_if.mem_gnt_i = 1'b1;
        tick(); mem_if.mem_gnt_i = 1'b0;
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'hA0A0_0001;
        tick(); mem_if.mem_rvalid_i = 1'b0; mem_if.mem_rdata_i = '0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || ir_d_o !== 32'hA0A0_0001) begin
            errors++;
            $display("FAIL b2b_first got busy=%b ir_d=%h, required 0 a0a00001", busy_o, ir_d_o);
        end
        tick(); fetch_req_i = 1'b0;
        checks++;
        if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h44) begin
            errors++;
            $display("FAIL b2b_second_req got req=%b addr=%h, required 1 00000044",
                     mem_if.mem_req_o, mem_if.mem_addr_o);
        end
        mem_if.mem_gnt_i = 1'b1;
        tick(); mem_if.mem_gnt_i = 1'b0;
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'hB0B0_0002;
        tick(); mem_if.mem_rvalid_i = 1'b0; mem_if.mem_rdata_i = '0;
        checks++;
        if (ir_d_o !== 32'hB0B0_0002) begin
            errors++;
            $display("FAIL b2b_second got ir_d=%h, required b0b00002", ir_d_o);
        end
        tick();
        last_ir = 32'hB0B0_0002;
    endtask

    task automatic test_timeout();
        int c = cyc;
        // No grant at all.
        fetch_req_i = 1'b1; pc_i = 32'h0000_0080;
        sb_q.push_back('{is_err: 1'b1, data: 32'h0, cause: ERR_TIMEOUT, cycle: c + 9});
        tick(); fetch_req_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (mem_if.mem_req_o !== 1'b1) begin
                errors++;
                $display("FAIL tmo_req_held_%0d got req=%b, required 1", k, mem_if.mem_req_o);
            end
            tick();
        end
        checks++;
        if (fetch_err_o !== 1'b1 || err_cause_o !== ERR_TIMEOUT || mem_if.mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_nogrant got err=%b cause=%b req=%b, required 1 11 0",
                     fetch_err_o, err_cause_o, mem_if.mem_req_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_nogrant_idle got busy=%b, required 0", busy_o);
        end
        // Grant but no response; the late response is drained silently.
        c = cyc;
        fetch_req_i = 1'b1; pc_i = 32'h0000_0084;
        sb_q.push_back('{is_err: 1'b1, data: 32'h0, cause: ERR_TIMEOUT, cycle: c + 9});
        tick(); fetch_req_i = 1'b0; mem_if.mem_gnt_i = 1'b1;
        tick(); mem_if.mem_gnt_i = 1'b0;
        repeat (7) tick();
        checks++;
        if (fetch_err_o !== 1'b1 || err_cause_o !== ERR_TIMEOUT) begin
            errors++;
            $display("FAIL tmo_wait got err=%b cause=%b, required 1 11", fetch_err_o, err_cause_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b1 || fetch_err_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_drain got busy=%b err=%b, required 1 0", busy_o, fetch_err_o);
        end
        tick();
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'hCAFE_F00D;
        tick(); mem_if.mem_rvalid_i = 1'b0; mem_if.mem_rdata_i = '0;
        checks++;
        if (busy_o !== 1'b0 || ir_en_o !== 1'b0 || ir_d_o !== last_ir) begin
            errors++;
            $display("FAIL tmo_drained got busy=%b en=%b ir_d=%h, required 0 0 %h",
                     busy_o, ir_en_o, ir_d_o, last_ir);
        end
    endtask

    task automatic test_flush();
        // Flush while waiting for the response.
        fetch_req_i = 1'b1; pc_i = 32'h0000_00C0;
        tick(); fetch_req_i = 1'b0; mem_if.mem_gnt_i = 1'b1;
        tick(); mem_if.mem_gnt_i = 1'b0; flush_i = 1'b1;
        tick(); flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || mem_if.mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain got busy=%b req=%b, required 1 0", busy_o, mem_if.mem_req_o);
        end
        tick();
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'hDEAD_BEEF;
        tick(); mem_if.mem_rvalid_i = 1'b0; mem_if.mem_rdata_i = '0;
        checks++;
        if (busy_o !== 1'b0 || ir_en_o !== 1'b0 || ir_d_o !== last_ir) begin
            errors++;
            $display("FAIL flush_wait got busy=%b en=%b ir_d=%h, required 0 0 %h",
                     busy_o, ir_en_o, ir_d_o, last_ir);
        end
        // Flush while still requesting, no grant.
        fetch_req_i = 1'b1; pc_i = 32'h0000_00C4;
        tick(); fetch_req_i = 1'b0; flush_i = 1'b1;
        tick(); flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || mem_if.mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_req got busy=%b req=%b, required 0 0", busy_o, mem_if.mem_req_o);
        end
    endtask

    task automatic test_async_reset();
        fetch_req_i = 1'b1; pc_i = 32'h0000_00E0;
        tick(); fetch_req_i = 1'b0; mem_if.mem_gnt_i = 1'b1;
        tick(); mem_if.mem_gnt_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({mem_if.mem_req_o, busy_o, ir_en_o, fetch_err_o} !== 4'b0 || mem_if.mem_addr_o !== RST_ADDR
            || ir_d_o !== 32'h0 || err_cause_o !== ERR_NONE) begin
            errors++;
            $display("FAIL async_reset got req/busy/en/err=%b%b%b%b addr=%h ir_d=%h cause=%b, required 0000 %h 0 00",
                     mem_if.mem_req_o, busy_o, ir_en_o, fetch_err_o, mem_if.mem_addr_o, ir_d_o, err_cause_o, RST_ADDR);
        end
        tick();
        #2 rst_ni = 1'b1;
        tick();
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'h1357_9BDF;
        tick(); mem_if.mem_rvalid_i = 1'b0; mem_if.mem_rdata_i = '0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || ir_en_o !== 1'b0 || ir_d_o !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_rvalid got busy=%b en=%b ir_d=%h, required 0 0 0",
                     busy_o, ir_en_o, ir_d_o);
        end
        last_ir = 32'h0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_delayed_grant();
        test_misaligned();
        test_bus_error();
        test_back_to_back();
        test_timeout();
        test_flush();
        test_async_reset();
        repeat (3) tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending completions, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
